// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency RAM.
// Port 0 has priority; a starvation counter forces port 1 through.
module mem_port_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic          rvalid0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          gnt_id,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   state_t        state_q, state_d;
   logic [3:0]    starve_q, starve_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          gnt_q, gnt_d;

   logic win0;
   logic win1;
   logic done;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      gnt_d       = gnt_q;
      win1        = req1 & ((starve_q == LIM) | ~req0);
      win0        = req0 & ~win1;
      unique case (state_q)
         S_IDLE: begin
            if (win1) begin
               gnt_d       = 1'b1;
               mem_addr_d  = addr1;
               mem_we_d    = we1;
               mem_wdata_d = wdata1;
               state_d     = S_ISSUE;
            end else if (win0) begin
               gnt_d       = 1'b0;
               mem_addr_d  = addr0;
               mem_we_d    = we0;
               mem_wdata_d = wdata0;
               state_d     = S_ISSUE;
            end
            // port 1 losing while asking is what counts as starvation
            if (win1 || !req1) begin
               starve_d = 4'd0;
            end else if (win0 && starve_q != LIM) begin
               starve_d = starve_q + 4'd1;
            end
         end
         S_ISSUE: begin
            mem_we_d = 1'b0;
            state_d  = mem_we_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         starve_q    <= 4'd0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         gnt_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         gnt_q       <= gnt_d;
      end
   end

   // writes complete in ISSUE, reads complete in WAIT
   assign done      = ((state_q == S_ISSUE) & mem_we_q) | (state_q == S_WAIT);
   assign ack0      = done & ~gnt_q;
   assign ack1      = done & gnt_q;
   assign rvalid0   = (state_q == S_WAIT) & ~gnt_q;
   assign rvalid1   = (state_q == S_WAIT) & gnt_q;
   assign rdata     = mem_rdata;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign gnt_id    = gnt_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model,
// directed scenarios followed by randomized requester traffic.
module tb_mem_port_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 16;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic          req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0, rvalid0, ack1, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          gnt_id, busy;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .gnt_id(gnt_id), .busy(busy)
   );

   always #5 clk = ~clk;

   bit [DW-1:0] ram [1024];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } rq_t;

   typedef struct packed {
      logic          own, gnt, issue, we;
      logic          ack0, ack1, rv0, rv1;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rdata;
   } ev_t;

   rq_t q0[$];
   rq_t q1[$];
   ev_t exp_q[int];
   bit [DW-1:0] ref_mem [1024];
   int cyc = 0;
   int free_cyc = 0;
   int starve = 0;
   int pass_cnt = 0;
   int total_cnt = 0;
   int gnt_log[$];
   int ack0_log[$];
   logic [DW-1:0] rd0_log[$];
   logic [DW-1:0] rd1_log[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      total_cnt++;
      assert (obs === exp_v) pass_cnt++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                  tag, cyc, obs, exp_v);
   endtask

   function automatic ev_t get_ev(int k);
      if (exp_q.exists(k)) return exp_q[k];
      return '0;
   endfunction

   function automatic rq_t mk(logic w, int a, int d);
      rq_t r;
      r.we = w;
      r.addr = AW'(a);
      r.wdata = DW'(d);
      return r;
   endfunction

   task automatic load0();
      rq_t r;
      if (q0.size() > 0) begin
         r = q0.pop_front();
         req0 = 1'b1; we0 = r.we; addr0 = r.addr; wdata0 = r.wdata;
      end else req0 = 1'b0;
   endtask

   task automatic load1();
      rq_t r;
      if (q1.size() > 0) begin
         r = q1.pop_front();
         req1 = 1'b1; we1 = r.we; addr1 = r.addr; wdata1 = r.wdata;
      end else req1 = 1'b0;
   endtask

   task automatic refill();
      if (!req0) load0();
      if (!req1) load1();
   endtask

   // Decide the arbitration at the coming edge from current inputs.
   task automatic model_decide();
      int w;
      ev_t e;
      logic we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (cyc < free_cyc) return;
      w = -1;
      if (req1 && (starve == LIM || !req0)) w = 1;
      else if (req0) w = 0;
      if (w == 1 || !req1) starve = 0;
      else if (starve < LIM) starve++;
      if (w < 0) return;
      we = (w == 1) ? we1 : we0;
      a  = (w == 1) ? addr1 : addr0;
      d  = (w == 1) ? wdata1 : wdata0;
      e = get_ev(cyc + 1);
      e.issue = 1'b1; e.own = 1'b1; e.gnt = (w == 1);
      e.we = we; e.addr = a; e.wdata = d;
      if (we) begin
         ref_mem[a] = d;
         if (w == 1) e.ack1 = 1'b1; else e.ack0 = 1'b1;
         exp_q[cyc + 1] = e;
         free_cyc = cyc + 2;
      end else begin
         exp_q[cyc + 1] = e;
         e = get_ev(cyc + 2);
         e.own = 1'b1; e.gnt = (w == 1); e.rdata = ref_mem[a];
         if (w == 1) begin e.ack1 = 1'b1; e.rv1 = 1'b1; end
         else begin e.ack0 = 1'b1; e.rv0 = 1'b1; end
         exp_q[cyc + 2] = e;
         free_cyc = cyc + 3;
      end
   endtask

   task automatic step();
      ev_t e;
      model_decide();
      @(posedge clk);
      #1;
      cyc++;
      e = get_ev(cyc);
      chk("ack0", 32'(ack0), 32'(e.ack0));
      chk("ack1", 32'(ack1), 32'(e.ack1));
      chk("rvalid0", 32'(rvalid0), 32'(e.rv0));
      chk("rvalid1", 32'(rvalid1), 32'(e.rv1));
      chk("busy", 32'(busy), 32'(cyc < free_cyc));
      chk("mem_we", 32'(mem_we), 32'(e.issue & e.we));
      if (e.own) chk("gnt_id", 32'(gnt_id), 32'(e.gnt));
      if (e.issue) begin
         chk("mem_addr", 32'(mem_addr), 32'(e.addr));
         if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
         gnt_log.push_back(int'(gnt_id));
      end
      if (e.rv0 | e.rv1) chk("rdata", 32'(rdata), 32'(e.rdata));
      if (ack0 === 1'b1) ack0_log.push_back(cyc);
      if (rvalid0 === 1'b1) rd0_log.push_back(rdata);
      if (rvalid1 === 1'b1) rd1_log.push_back(rdata);
      exp_q.delete(cyc);
      if (ack0 === 1'b1 || !req0) load0();
      if (ack1 === 1'b1 || !req1) load1();
   endtask

   task automatic reset_step(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
      rst = 1'b0;
      exp_q.delete();
      free_cyc = cyc;
      starve = 0;
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_rvalid0", 32'(rvalid0), 0);
      chk("rst_rvalid1", 32'(rvalid1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_gnt_id", 32'(gnt_id), 0);
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 ||
              cyc < free_cyc) && n < budget) begin
         step();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 1);
   endtask

   int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      // reset with both ports requesting; then write/read 0x012
      q0.push_back(mk(1'b1, 'h012, 'hBEEF));
      q0.push_back(mk(1'b0, 'h012, 0));
      q1.push_back(mk(1'b0, 'h3FF, 0));
      refill();
      reset_step(2);
      run_until_idle(60);
      chk("grant_count", 32'(gnt_log.size()), 3);
      if (gnt_log.size() > 0) chk("first_gnt", 32'(gnt_log[0]), 0);
      chk("rd0_count", 32'(rd0_log.size()), 1);
      if (rd0_log.size() > 0) chk("rd0_beef", 32'(rd0_log[0]), 'hBEEF);

      // sustained contention
      gnt_log.delete();
      for (int i = 0; i < 12; i++) q0.push_back(mk(1'b1, 'h20 + i, 'h1000 + i));
      q1.push_back(mk(1'b0, 'h20, 0));
      q1.push_back(mk(1'b0, 'h21, 0));
      refill();
      run_until_idle(200);
      for (int i = 0; i < 10; i++)
         if (i < gnt_log.size()) chk($sformatf("gnt_seq%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
         else chk($sformatf("gnt_seq%0d_missing", i), 0, 1);

      // port 1 alone at the top address
      rd1_log.delete();
      q1.push_back(mk(1'b1, 'h3FF, 'hA5A5));
      q1.push_back(mk(1'b0, 'h3FF, 0));
      refill();
      run_until_idle(60);
      chk("rd1_count", 32'(rd1_log.size()), 1);
      if (rd1_log.size() > 0) chk("rd1_top", 32'(rd1_log[0]), 'hA5A5);

      // reset during ISSUE of a read, then during WAIT
      rd0_log.delete();
      q0.push_back(mk(1'b0, 'h20, 0));
      refill();
      step();
      reset_step(1);
      run_until_idle(60);
      chk("reissued_read", 32'(rd0_log.size()), 1);
      if (rd0_log.size() > 0) chk("reissued_data", 32'(rd0_log[0]), 'h1000);
      q0.push_back(mk(1'b0, 'h21, 0));
      refill();
      step();
      step();
      reset_step(1);
      run_until_idle(60);

      // starvation count must clear on reset
      for (int i = 0; i < 10; i++) q0.push_back(mk(1'b1, 'h40 + i, 'h2000 + i));
      q1.push_back(mk(1'b0, 'h40, 0));
      refill();
      repeat (6) step();
      reset_step(1);
      gnt_log.delete();
      run_until_idle(200);
      for (int i = 0; i < 5; i++)
         if (i < gnt_log.size()) chk($sformatf("post_rst_gnt%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
         else chk($sformatf("post_rst_gnt%0d_missing", i), 0, 1);

      // back-to-back writes from port 0
      ack0_log.delete();
      q0.push_back(mk(1'b1, 'h001, 'h0111));
      q0.push_back(mk(1'b1, 'h002, 'h0222));
      q0.push_back(mk(1'b1, 'h003, 'h0333));
      refill();
      run_until_idle(60);
      chk("b2b_acks", 32'(ack0_log.size()), 3);
      for (int i = 1; i < ack0_log.size(); i++)
         chk("b2b_spacing", 32'(ack0_log[i] - ack0_log[i-1]), 2);
      chk("ram1", 32'(ram[1]), 'h0111);
      chk("ram2", 32'(ram[2]), 'h0222);
      chk("ram3", 32'(ram[3]), 'h0333);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         if (q0.size() < 2 && $urandom_range(2) == 0)
            q0.push_back(mk(1'($urandom), ($urandom_range(4) == 0) ? 'h3FF : int'($urandom_range(15)),
                            int'($urandom_range(16'hFFFF))));
         if (q1.size() < 2 && $urandom_range(2) == 0)
            q1.push_back(mk(1'($urandom), ($urandom_range(4) == 0) ? 'h3FF : int'($urandom_range(15)),
                            int'($urandom_range(16'hFFFF))));
         if ($urandom_range(199) == 0) reset_step(1);
         else begin
            refill();
            step();
         end
      end
      run_until_idle(100);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, 1-cycle-read-latency data/instruction RAM between two requesters: port 0 is the CPU control FSM (fetch/load/store), port 1 is a secondary master (display/DMA reader).
- Port 0 normally has priority; a starvation counter guarantees port 1 eventually wins.
- Sits between the requesters and the RAM address/we/data pins; one access in flight at a time.

Parameters:
- AW, 10, address width
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations by port 1 before it is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request, level; held with we0/addr0/wdata0 stable until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- ack0  out  1  port 0 access complete, one-cycle pulse
- rvalid0  out  1  rdata valid for port 0, one-cycle pulse
- req1, we1, addr1, wdata1, ack1, rvalid1  (same as port 0, for port 1)
- rdata  out  DW  shared read data, valid only when rvalid0 or rvalid1 is high
- mem_addr  out  AW  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DW  RAM write data, registered
- mem_rdata  in  DW  RAM read data, valid the cycle after the address is presented
- gnt_id  out  1  port currently owning the RAM
- busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset: state=IDLE, starve_cnt=0.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, ack0/1=0, rvalid0/1=0, gnt_id=0, busy=0.
- Reset mid-access abandons the transfer with no ack or rvalid. A write whose ISSUE cycle coincides with the rst edge is still committed by the RAM.
- States: IDLE, ISSUE, WAIT.
- IDLE, at each clock edge, decision:
  - req1 & (starve_cnt==STARVE_LIMIT | ~req0) -> port 1 wins.
  - Otherwise, if req0 -> port 0 wins.
  - Otherwise stay in IDLE.
  - On a win: latch the winner's addr/we/wdata into mem_*, set gnt_id, go to ISSUE.
- starve_cnt, updated at IDLE decisions:
  - Increment, saturating at STARVE_LIMIT, when port 0 wins while req1=1.
  - Clear when port 1 wins or req1=0.
  - Hold otherwise.
- ISSUE, 1 cycle, busy=1:
  - Write: ack[gnt_id]=1; next state IDLE; mem_we drops to 0 on exit.
  - Read: no ack; next state WAIT; mem_we=0.
- WAIT, 1 cycle:
  - rdata = mem_rdata (combinational pass-through).
  - rvalid[gnt_id]=1 and ack[gnt_id]=1.
  - Next state IDLE.
- Latency from the first IDLE cycle with req high, when uncontested: write ack 1 cycle later; read data 2 cycles later. Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Requester rule: deassert req, or present the next request, on the edge that ends the ack cycle. Arbiter never samples req during ISSUE/WAIT.
- Simultaneous req0 & req1 with starve_cnt<STARVE_LIMIT: port 0 wins. The loser keeps its request pending with inputs held; nothing is dropped.
- rdata when no rvalid: don't-care. Bench checks it only under rvalid.
- ack0/ack1 and rvalid0/rvalid1 are never high in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with req0=req1=1 -> all outputs 0, state IDLE; first grant goes to port 0 on the first post-reset edge.
- Port 0 write: addr0=0x012, wdata0=0xBEEF, we0=1 -> next cycle mem_addr=0x012, mem_we=1, ack0=1; then port 0 read of 0x012 -> rvalid0=1, rdata=0xBEEF two cycles after the decision edge.
- Contention: req0 and req1 held continuously with STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; port 1 wins exactly at the 5th decision.
- Port 1 alone: req1 read of addr 0x3FF (wrap-top address) -> gnt_id=1, rvalid1=1, ack1=1 in WAIT; ack0/rvalid0 stay 0.
- Reset mid-read: assert rst during WAIT -> rvalid0=0 next cycle, busy=0, starve_cnt=0; re-issued request completes normally.
- Back-to-back: port 0 issues writes to 0x001, 0x002, 0x003 with req held and inputs advanced on each ack -> three ack0 pulses spaced 2 cycles apart; RAM contents match.
